// File: rtl/spi_logic_master.sv
// spi_logic_master: single-channel SPI master (8/16/32-bit, CPOL/CPHA, MSB/LSB first).
// Optional build macro SPI_LOOPBACK_EN: SPI_CTRL[7] routes MOSI back into the
// receive shifter in place of MISO. When undefined, MISO is always used.
module spi_logic_master (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic [31:0] SPI_BITRATE,
  input  logic [31:0] SPI_DATA_OUT,
  output logic [31:0] SPI_DATA_IN,
  input  logic [8:0]  SPI_CTRL,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS,
  output logic        IRQ_SPI
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [31:0] h_q, h_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  edge_q, edge_d;
  logic [1:0]  size_q, size_d;
  logic        cpha_q, cpha_d, cpol_q, cpol_d, msb_q, msb_d, irqen_q, irqen_d;
  logic        lb_q, lb_d;
  logic [31:0] tx_q, tx_d, rx_q, rx_d, din_q, din_d;
  logic        sck_q, sck_d, mosi_q, mosi_d, ss_q, ss_d, irq_q, irq_d;

  logic        start_edge, tick, leading, do_sample, do_drive, rx_in;
  logic [6:0]  n2, k;

  assign start_edge = SPI_CTRL[1] & ~start_q & SPI_CTRL[2];

`ifdef SPI_LOOPBACK_EN
  assign rx_in = lb_q ? mosi_q : MISO;
`else
  logic unused_lb;
  assign unused_lb = SPI_CTRL[7] | lb_q;
  assign rx_in     = MISO;
`endif

  // Number of SCK edges for the latched transfer size (two per bit)
  always_comb begin
    case (size_q)
      2'b00:   n2 = 7'd16;
      2'b01:   n2 = 7'd32;
      default: n2 = 7'd64;
    endcase
  end

  // Next-state and datapath: all outputs are registered so pins never glitch
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    size_d    = size_q;
    cpha_d    = cpha_q;
    cpol_d    = cpol_q;
    msb_d     = msb_q;
    irqen_d   = irqen_q;
    lb_d      = lb_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    din_d     = din_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    // Completion flag drops once software lowers START
    irq_d     = irq_q & SPI_CTRL[1];
    tick      = 1'b0;
    k         = edge_q + 7'd1;
    leading   = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;

    case (state_q)
      IDLE: begin
        ss_d  = 1'b1;
        sck_d = SPI_CTRL[6];
        if (start_edge) begin
          state_d = SHIFT;
          h_d     = (SPI_BITRATE == 32'd0) ? 32'd1 : SPI_BITRATE;
          cnt_d   = 32'd0;
          edge_d  = 7'd0;
          size_d  = SPI_CTRL[5:4];
          cpha_d  = SPI_CTRL[0];
          cpol_d  = SPI_CTRL[6];
          msb_d   = SPI_CTRL[3];
          irqen_d = SPI_CTRL[8];
          lb_d    = SPI_CTRL[7];
          rx_d    = 32'd0;
          irq_d   = 1'b0;
          ss_d    = 1'b0;
          // MSB-first words are left-aligned so the next bit is always tx[31]
          if (SPI_CTRL[3]) begin
            case (SPI_CTRL[5:4])
              2'b00:   tx_d = {SPI_DATA_OUT[7:0], 24'd0};
              2'b01:   tx_d = {SPI_DATA_OUT[15:0], 16'd0};
              default: tx_d = SPI_DATA_OUT;
            endcase
            mosi_d = tx_d[31];
          end else begin
            tx_d   = SPI_DATA_OUT;
            mosi_d = SPI_DATA_OUT[0];
          end
        end
      end

      SHIFT: begin
        if (!SPI_CTRL[2]) begin
          // Abort: drop the transfer without touching received data or IRQ
          state_d = IDLE;
          ss_d    = 1'b1;
          sck_d   = cpol_q;
        end else begin
          tick  = (cnt_q == h_q - 32'd1);
          cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
          if (tick) begin
            if (edge_q == n2) begin
              // Final half-period elapsed: publish the received word
              state_d = DONE;
              ss_d    = 1'b1;
              irq_d   = irqen_q;
              if (msb_q) din_d = rx_q;
              else begin
                case (size_q)
                  2'b00:   din_d = rx_q >> 24;
                  2'b01:   din_d = rx_q >> 16;
                  default: din_d = rx_q;
                endcase
              end
            end else begin
              edge_d    = k;
              sck_d     = ~sck_q;
              leading   = k[0];
              do_sample = cpha_q ? ~leading : leading;
              // First bit is already on MOSI; never drive past the last bit
              do_drive  = cpha_q ? (leading && k != 7'd1) : (~leading && k != n2);
              if (do_sample)
                rx_d = msb_q ? {rx_q[30:0], rx_in} : {rx_in, rx_q[31:1]};
              if (do_drive) begin
                tx_d   = msb_q ? (tx_q << 1) : (tx_q >> 1);
                mosi_d = msb_q ? tx_q[30] : tx_q[1];
              end
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        ss_d    = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      h_q     <= 32'd1;
      cnt_q   <= 32'd0;
      edge_q  <= 7'd0;
      size_q  <= 2'b00;
      cpha_q  <= 1'b0;
      cpol_q  <= 1'b0;
      msb_q   <= 1'b0;
      irqen_q <= 1'b0;
      lb_q    <= 1'b0;
      tx_q    <= 32'd0;
      rx_q    <= 32'd0;
      din_q   <= 32'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= SPI_CTRL[1];
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      size_q  <= size_d;
      cpha_q  <= cpha_d;
      cpol_q  <= cpol_d;
      msb_q   <= msb_d;
      irqen_q <= irqen_d;
      lb_q    <= lb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      din_q   <= din_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      irq_q   <= irq_d;
    end
  end

  assign SPI_DATA_IN = din_q;
  assign SCK         = sck_q;
  assign MOSI        = mosi_q;
  assign SS          = ss_q;
  assign IRQ_SPI     = irq_q;

endmodule

// File: tb/tb_spi_logic_master.sv
// Self-checking bench for spi_logic_master: directed + random transfers against
// an arithmetic timing/bit-order model.
module tb_spi_logic_master;
  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [31:0] SPI_BITRATE, SPI_DATA_OUT, SPI_DATA_IN;
  logic [8:0]  SPI_CTRL;
  logic        SCK, MOSI, MISO, SS, IRQ_SPI;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_din = 32'd0;

  spi_logic_master dut (
    .clk_cpu(clk_cpu), .rst(rst), .SPI_BITRATE(SPI_BITRATE),
    .SPI_DATA_OUT(SPI_DATA_OUT), .SPI_DATA_IN(SPI_DATA_IN), .SPI_CTRL(SPI_CTRL),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SS(SS), .IRQ_SPI(IRQ_SPI)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit index currently presented on the line after 'edges' SCK edges
  function automatic int cur_idx(input int edges, input logic cpha, input int n);
    int i;
    if (cpha) i = (edges == 0) ? 0 : (edges - 1) / 2;
    else      i = edges / 2;
    if (i > n - 1) i = n - 1;
    return i;
  endfunction

  function automatic logic pick(input logic [31:0] w, input int i, input logic msb, input int n);
    return msb ? w[n - 1 - i] : w[i];
  endfunction

  // One transfer; abort_e > 0 drops EN once that many SCK edges have occurred
  task automatic xfer(input logic [31:0] br, input logic [31:0] dout, input logic [8:0] ctrl,
                      input logic [31:0] mword, input int abort_e);
    int n, h, last, edges, sslow, idx;
    logic [31:0] mask, exp_rx;
    logic cpha, cpol, msb, lb;
    n    = ctrl[5] ? 32 : (ctrl[4] ? 16 : 8);
    h    = (br == 0) ? 1 : int'(br);
    cpha = ctrl[0]; cpol = ctrl[6]; msb = ctrl[3];
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    lb   = 1'b0;
`ifdef SPI_LOOPBACK_EN
    lb   = ctrl[7];
`endif
    exp_rx = lb ? (dout & mask) : (mword & mask);
    last   = 1 + (2 * n + 1) * h;
    sslow  = 0;
    @(negedge clk_cpu);
    SPI_BITRATE  = br;
    SPI_DATA_OUT = dout;
    SPI_CTRL     = ctrl & ~9'h002;
    MISO         = pick(mword, 0, msb, n);
    @(negedge clk_cpu);
    SPI_CTRL     = ctrl | 9'h002;
    for (int j = 1; j <= last + 1; j++) begin
      @(negedge clk_cpu);
      edges = (j - 1) / h;
      if (edges > 2 * n) edges = 2 * n;
      idx = cur_idx(edges, cpha, n);
      if (j < last) begin
        if (SS === 1'b0) sslow++;
        if (j == 1) chk("ss_fall", {31'd0, SS}, 32'd0);
        chk("sck", {31'd0, SCK}, {31'd0, cpol ^ edges[0]});
        chk("mosi", {31'd0, MOSI}, {31'd0, pick(dout, idx, msb, n)});
        MISO = pick(mword, idx, msb, n);
        if (abort_e > 0 && edges == abort_e && SPI_CTRL[2]) begin
          SPI_CTRL[2] = 1'b0;
          @(negedge clk_cpu);
          chk("abort_ss", {31'd0, SS}, 32'd1);
          chk("abort_sck", {31'd0, SCK}, {31'd0, cpol});
          chk("abort_din", SPI_DATA_IN, model_din);
          chk("abort_irq", {31'd0, IRQ_SPI}, 32'd0);
          return;
        end
      end else if (j == last) begin
        chk("done_ss", {31'd0, SS}, 32'd1);
        chk("done_din", SPI_DATA_IN, exp_rx);
        chk("done_irq", {31'd0, IRQ_SPI}, {31'd0, ctrl[8]});
        model_din = exp_rx;
      end else begin
        chk("idle_ss", {31'd0, SS}, 32'd1);
        chk("idle_sck", {31'd0, SCK}, {31'd0, cpol});
        chk("irq_hold", {31'd0, IRQ_SPI}, {31'd0, ctrl[8]});
      end
    end
    chk("ss_low_len", sslow, last - 1);
  endtask

  initial begin
    int sck_edges;
    logic prev_sck;
    rst = 1'b1; SPI_BITRATE = 0; SPI_DATA_OUT = 0; SPI_CTRL = 0; MISO = 0;
    repeat (10) @(negedge clk_cpu);
    chk("rst_ss", {31'd0, SS}, 32'd1);
    chk("rst_sck", {31'd0, SCK}, 32'd0);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_irq", {31'd0, IRQ_SPI}, 32'd0);
    chk("rst_din", SPI_DATA_IN, 32'd0);
    rst = 1'b0;

    // Control held without a START edge: bus stays quiet
    SPI_CTRL = 9'h10D; SPI_BITRATE = 2;
    sck_edges = 0; prev_sck = SCK;
    repeat (20) begin
      @(negedge clk_cpu);
      if (SCK !== prev_sck) sck_edges++;
      prev_sck = SCK;
    end
    chk("no_start_sck", sck_edges, 0);
    chk("no_start_ss", {31'd0, SS}, 32'd1);

    // 8-bit MSB first, CPHA=1, CPOL=0, MISO all ones
    xfer(32'd2, 32'd9, 9'h10D, 32'hFFFF_FFFF, 0);
    @(negedge clk_cpu); SPI_CTRL = 9'h10D;
    @(negedge clk_cpu);
    chk("irq_clear", {31'd0, IRQ_SPI}, 32'd0);

    // 32-bit CPHA=0, MISO zero
    xfer(32'd2, 32'd169, 9'h12C, 32'd0, 0);
    // 16-bit LSB first, MISO 1 on the first sampled bit only
    xfer(32'd1, 32'h0001, 9'h114, 32'h0001, 0);
    // Abort after 3 SCK pulses
    xfer(32'd2, 32'h1234, 9'h114, 32'hBEEF, 6);
    // Loopback request (MISO ignored only when the feature is built in)
    xfer(32'd1, 32'hA5, 9'h18C, 32'd0, 0);
    // BITRATE 0 behaves as 1, CPOL=1
    xfer(32'd0, 32'h5A, 9'h14D, 32'h3C, 0);

    // Randomized transfers
    for (int r = 0; r < 10; r++) begin
      logic [8:0] c;
      c = 9'h004;
      c[0] = 1'($urandom_range(0, 1));
      c[3] = 1'($urandom_range(0, 1));
      c[5:4] = 2'($urandom_range(0, 3));
      c[6] = 1'($urandom_range(0, 1));
      c[8] = 1'($urandom_range(0, 1));
      xfer(32'($urandom_range(0, 3)), $urandom, c, $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
